// File: rtl/md_dispatch_pkg.sv
// Shared types for the pair dispatcher: FSM states, particle position, drain constants.
// Optional feature macro used by the dispatcher: PAIR_DISPATCH_HALF_HOME_EN.
package md_dispatch_pkg;

    localparam int DRAIN_EMPTY_CYCLES = 2;
    localparam int POS_WIDTH          = 32;

    typedef enum logic [2:0] {
        IDLE,
        REF_RD,
        REF_LATCH,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } dispatch_state_t;

    typedef struct packed {
        logic [POS_WIDTH-1:0] z;
        logic [POS_WIDTH-1:0] y;
        logic [POS_WIDTH-1:0] x;
    } particle_pos_t;

endpackage

// File: rtl/max_count_reduce.sv
// Combinational max over NUM packed counts, evaluated as a balanced pairwise tree.
// Unused leaves (NUM not a power of two) are padded with zero.
module max_count_reduce #(
    parameter int NUM   = 7,
    parameter int WIDTH = 7
) (
    input  logic [NUM*WIDTH-1:0] counts,
    output logic [WIDTH-1:0]     max_count
);

    localparam int P = 1 << $clog2(NUM);

    // Reduce leaves level by level; each level folds pairs into the lower half.
    always_comb begin
        logic [WIDTH-1:0] node [P];
        for (int i = 0; i < P; i++) node[i] = '0;
        for (int i = 0; i < NUM; i++) node[i] = counts[i*WIDTH +: WIDTH];
        for (int s = P / 2; s >= 1; s = s / 2) begin
            for (int i = 0; i < s; i++) begin
                node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
            end
        end
        max_count = node[0];
    end

endmodule

// File: rtl/pair_dispatcher.sv
// Streams neighbour particles of every home particle into the filter bank lanes.
// Define PAIR_DISPATCH_HALF_HOME_EN for half pairing in the home lane (idx > ref).
module pair_dispatcher
    import md_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_FILTER        = 7,
    parameter int FILTER_LATENCY    = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [PARTICLE_ID_WIDTH-1:0]            home_count,
    input  logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] nb_count,
    output logic [PARTICLE_ID_WIDTH-1:0]            ref_rd_addr,
    input  logic [3*DATA_WIDTH-1:0]                 ref_rd_data,
    output logic [PARTICLE_ID_WIDTH-1:0]            nb_rd_addr,
    input  logic [NUM_FILTER*3*DATA_WIDTH-1:0]      nb_rd_data,
    output logic [NUM_FILTER*DATA_WIDTH-1:0]        nb_x,
    output logic [NUM_FILTER*DATA_WIDTH-1:0]        nb_y,
    output logic [NUM_FILTER*DATA_WIDTH-1:0]        nb_z,
    output logic [PARTICLE_ID_WIDTH-1:0]            nb_id_in,
    output logic [NUM_FILTER-1:0]                   input_valid,
    output logic [DATA_WIDTH-1:0]                   ref_x,
    output logic [DATA_WIDTH-1:0]                   ref_y,
    output logic [DATA_WIDTH-1:0]                   ref_z,
    output logic [PARTICLE_ID_WIDTH-1:0]            ref_id,
    input  logic [NUM_FILTER-1:0]                   back_pressure,
    input  logic                                    all_buffer_empty,
    output logic                                    busy,
    output logic                                    done
);

    localparam int W  = PARTICLE_ID_WIDTH;
    localparam int DW = $clog2(FILTER_LATENCY + 2);

    dispatch_state_t state, state_n;

    logic [W-1:0]            home_q;
    logic [W-1:0]            max_q;
    logic [W-1:0]            max_nb;
    logic [W-1:0]            ref_idx;
    logic [W-1:0]            nb_idx;
    logic [W-1:0]            idx_d;
    logic [NUM_FILTER*W-1:0] nb_cnt_q;
    logic                    issue_v;
    logic                    issue_v_d;
    logic                    drain_ok;
    logic                    advance;
    logic                    self_ok;
    logic [DW-1:0]           drain_cnt;
    logic [1:0]              empty_cnt;
    particle_pos_t           ref_pos;

    max_count_reduce #(
        .NUM   (NUM_FILTER),
        .WIDTH (W)
    ) u_max (
        .counts    (nb_count),
        .max_count (max_nb)
    );

    assign issue_v  = (state == STREAM) && !(|back_pressure);
    assign drain_ok = (drain_cnt == DW'(FILTER_LATENCY));
    assign advance  = (state == DRAIN) && drain_ok && all_buffer_empty
                   && (empty_cnt == 2'(DRAIN_EMPTY_CYCLES - 1));

    assign ref_rd_addr = ref_idx;
    assign nb_rd_addr  = nb_idx;
    assign nb_id_in    = idx_d;
    assign ref_x       = ref_pos.x;
    assign ref_y       = ref_pos.y;
    assign ref_z       = ref_pos.z;

`ifdef PAIR_DISPATCH_HALF_HOME_EN
    assign self_ok = (idx_d > ref_id);
`else
    assign self_ok = (idx_d != ref_id);
`endif

    for (genvar i = 0; i < NUM_FILTER; i++) begin : g_lane
        localparam int B = i * 3 * DATA_WIDTH;
        logic in_range;
        assign in_range = issue_v_d && (idx_d < nb_cnt_q[i*W +: W]);
        if (i == 0) begin : g_home
            assign input_valid[i] = in_range && self_ok;
        end else begin : g_nb
            assign input_valid[i] = in_range;
        end
        assign nb_x[i*DATA_WIDTH +: DATA_WIDTH] =
            issue_v_d ? nb_rd_data[B +: DATA_WIDTH] : '0;
        assign nb_y[i*DATA_WIDTH +: DATA_WIDTH] =
            issue_v_d ? nb_rd_data[B + DATA_WIDTH +: DATA_WIDTH] : '0;
        assign nb_z[i*DATA_WIDTH +: DATA_WIDTH] =
            issue_v_d ? nb_rd_data[B + 2*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (start) state_n = (home_count == '0) ? DONE : REF_RD;
            REF_RD:    state_n = REF_LATCH;
            REF_LATCH: state_n = (max_q == '0) ? DRAIN : STREAM;
            STREAM:    if (issue_v && nb_idx == max_q - W'(1)) state_n = FLUSH;
            FLUSH:     state_n = DRAIN;
            DRAIN:     if (advance) state_n = (ref_idx == home_q - W'(1)) ? DONE : REF_RD;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Pass configuration, indices, reference latch, drain timers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            home_q    <= '0;
            max_q     <= '0;
            nb_cnt_q  <= '0;
            ref_idx   <= '0;
            nb_idx    <= '0;
            idx_d     <= '0;
            issue_v_d <= 1'b0;
            ref_pos   <= '0;
            ref_id    <= '0;
            drain_cnt <= '0;
            empty_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            issue_v_d <= issue_v;
            idx_d     <= nb_idx;
            done      <= (state == DONE);
            if (state == IDLE && start) begin
                home_q   <= home_count;
                nb_cnt_q <= nb_count;
                max_q    <= max_nb;
                ref_idx  <= '0;
                busy     <= 1'b1;
            end
            if (state == DONE) busy <= 1'b0;
            if (state == REF_LATCH) begin
                ref_pos <= ref_rd_data;
                ref_id  <= ref_idx;
                nb_idx  <= '0;
            end
            if (issue_v) nb_idx <= nb_idx + W'(1);
            if (state != DRAIN) begin
                drain_cnt <= '0;
                empty_cnt <= '0;
            end else if (!drain_ok) begin
                drain_cnt <= drain_cnt + DW'(1);
            end else if (all_buffer_empty) begin
                empty_cnt <= empty_cnt + 2'd1;
            end else begin
                empty_cnt <= '0;
            end
            if (advance && state_n == REF_RD) ref_idx <= ref_idx + W'(1);
        end
    end

endmodule

// File: tb/tb_pair_dispatcher.sv
// Randomized bench for pair_dispatcher against a pair-list model built from the pairing rules.
// Honours PAIR_DISPATCH_HALF_HOME_EN for the home-lane rule.
module tb_pair_dispatcher;

    localparam int DW = 32;
    localparam int IW = 7;
    localparam int NF = 7;
    localparam int FL = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [IW-1:0]     home_count;
    logic [NF*IW-1:0]  nb_count;
    logic [IW-1:0]     ref_rd_addr;
    logic [3*DW-1:0]   ref_rd_data;
    logic [IW-1:0]     nb_rd_addr;
    logic [NF*3*DW-1:0] nb_rd_data;
    logic [NF*DW-1:0]  nb_x, nb_y, nb_z;
    logic [IW-1:0]     nb_id_in;
    logic [NF-1:0]     input_valid;
    logic [DW-1:0]     ref_x, ref_y, ref_z;
    logic [IW-1:0]     ref_id;
    logic [NF-1:0]     back_pressure;
    logic              all_buffer_empty;
    logic              busy;
    logic              done;

    pair_dispatcher #(
        .DATA_WIDTH        (DW),
        .PARTICLE_ID_WIDTH (IW),
        .NUM_FILTER        (NF),
        .FILTER_LATENCY    (FL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .home_count       (home_count),
        .nb_count         (nb_count),
        .ref_rd_addr      (ref_rd_addr),
        .ref_rd_data      (ref_rd_data),
        .nb_rd_addr       (nb_rd_addr),
        .nb_rd_data       (nb_rd_data),
        .nb_x             (nb_x),
        .nb_y             (nb_y),
        .nb_z             (nb_z),
        .nb_id_in         (nb_id_in),
        .input_valid      (input_valid),
        .ref_x            (ref_x),
        .ref_y            (ref_y),
        .ref_z            (ref_z),
        .ref_id           (ref_id),
        .back_pressure    (back_pressure),
        .all_buffer_empty (all_buffer_empty),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3*DW-1:0] ref_mem [128];
    logic [3*DW-1:0] nb_mem  [NF][128];
    logic [13:0]     exp_q   [NF][$];
    int              exp_cnt [NF];
    int              lane_cnt[NF];
    int              cfg_cnt [NF];
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous-read memories, one cycle from address to data.
    always @(posedge clk) begin
        ref_rd_data <= ref_mem[ref_rd_addr];
        for (int i = 0; i < NF; i++)
            nb_rd_data[i*3*DW +: 3*DW] <= nb_mem[i][nb_rd_addr];
    end

    // Every valid lane must present the next expected pair with matching coordinates.
    always @(negedge clk) begin
        logic [13:0] e;
        if (rst_n) begin
            for (int i = 0; i < NF; i++) begin
                if (input_valid[i]) begin
                    lane_cnt[i]++;
                    check("pair_expected", 128'(exp_q[i].size() != 0), 128'(1));
                    if (exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        check("pair_ref_nb", {ref_id, nb_id_in}, e);
                    end
                    check("nb_coord", {nb_z[i*DW +: DW], nb_y[i*DW +: DW],
                                       nb_x[i*DW +: DW]}, nb_mem[i][nb_id_in]);
                    check("ref_coord", {ref_z, ref_y, ref_x}, ref_mem[ref_id]);
                end
            end
        end
    end

    function automatic bit home_pair_ok(int r, int j);
`ifdef PAIR_DISPATCH_HALF_HOME_EN
        return j > r;
`else
        return j != r;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_model(input int hc);
        for (int i = 0; i < NF; i++) begin
            exp_q[i].delete();
            exp_cnt[i]  = 0;
            lane_cnt[i] = 0;
        end
        for (int r = 0; r < hc; r++)
            for (int i = 0; i < NF; i++)
                for (int j = 0; j < cfg_cnt[i]; j++)
                    if (i != 0 || home_pair_ok(r, j)) begin
                        exp_q[i].push_back({7'(r), 7'(j)});
                        exp_cnt[i]++;
                    end
    endtask

    task automatic start_pass(input int hc);
        load_model(hc);
        home_count = 7'(hc);
        for (int i = 0; i < NF; i++) nb_count[i*IW +: IW] = 7'(cfg_cnt[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic finish_pass(input int bp_pct, input int abe_pct, input bit stray);
        bit seen = 0;
        for (int c = 0; c < 20000; c++) begin
            back_pressure = ($urandom_range(99) < bp_pct) ?
                            7'(1 << $urandom_range(NF - 1)) : '0;
            all_buffer_empty = ($urandom_range(99) < abe_pct);
            if (stray) begin
                start = (c == 7);
                if (c == 7) home_count = 7'($urandom_range(1, 9));
            end
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
        start = 1'b0;
        check("done_seen", 128'(seen), 128'(1));
        check("busy_at_done", 128'(busy), 128'(0));
        #1;
        for (int i = 0; i < NF; i++) begin
            check("lane_pairs_left", 128'(exp_q[i].size()), 128'(0));
            check("lane_pair_count", 128'(lane_cnt[i]), 128'(exp_cnt[i]));
        end
        tick();
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'(0));
        tick();
        back_pressure    = '0;
        all_buffer_empty = 1'b1;
        if (!seen) do_reset();
    endtask

    task automatic wait_first_valid(output bit ok);
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|input_valid) begin
                ok = 1;
                break;
            end
        end
        check("first_valid_seen", 128'(ok), 128'(1));
        tick();
    endtask

    task automatic set_counts(input int v);
        for (int i = 0; i < NF; i++) cfg_cnt[i] = v;
    endtask

    initial begin
        bit ok;
        int n;
        int vcnt;
        logic [IW-1:0] a0;
        for (int a = 0; a < 128; a++) begin
            ref_mem[a] = {$urandom, $urandom, $urandom};
            for (int i = 0; i < NF; i++) nb_mem[i][a] = {$urandom, $urandom, $urandom};
        end
        rst_n = 1'b0;
        start = 1'b0;
        home_count = '0;
        nb_count = '0;
        back_pressure = '0;
        all_buffer_empty = 1'b1;
        set_counts(0);
        load_model(0);
        tick();
        tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(input_valid), 128'(0));
        check("rst_ref_addr", 128'(ref_rd_addr), 128'(0));
        check("rst_nb_addr", 128'(nb_rd_addr), 128'(0));
        check("rst_ref_pos", {ref_z, ref_y, ref_x}, 128'(0));
        check("rst_ref_id", 128'(ref_id), 128'(0));
        rst_n = 1'b1;
        tick();

        set_counts(3);
        start_pass(2);
        finish_pass(0, 100, 0);
`ifdef PAIR_DISPATCH_HALF_HOME_EN
        check("basic_home_lane", 128'(lane_cnt[0]), 128'(3));
`else
        check("basic_home_lane", 128'(lane_cnt[0]), 128'(4));
`endif
        check("basic_lane1", 128'(lane_cnt[1]), 128'(6));

        set_counts(20);
        start_pass(1);
        wait_first_valid(ok);
        tick();
        back_pressure = 7'b0001000;
        vcnt = 0;
        a0 = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) a0 = nb_rd_addr;
            else check("bp_addr_frozen", 128'(nb_rd_addr), 128'(a0));
            vcnt += int'(|input_valid);
            tick();
        end
        back_pressure = '0;
        check("bp_inflight_valids", 128'(vcnt), 128'(1));
        finish_pass(0, 100, 0);

        cfg_cnt = '{0, 5, 0, 2, 0, 0, 1};
        start_pass(3);
        finish_pass(30, 80, 0);
        check("mask_lane3", 128'(lane_cnt[3]), 128'(6));

        set_counts(3);
        all_buffer_empty = 1'b0;
        start_pass(2);
        repeat (10) tick();
        @(negedge clk);
        check("drain_addr_early", 128'(ref_rd_addr), 128'(0));
        check("drain_ref_early", {ref_z, ref_y, ref_x}, ref_mem[0]);
        repeat (20) tick();
        @(negedge clk);
        check("drain_addr_late", 128'(ref_rd_addr), 128'(0));
        check("drain_ref_late", {ref_z, ref_y, ref_x}, ref_mem[0]);
        tick();
        all_buffer_empty = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ref_rd_addr != 0) break;
            n++;
            tick();
        end
        check("drain_advance_delay", 128'(n), 128'(2));
        tick();
        finish_pass(0, 100, 0);

        set_counts(4);
        load_model(0);
        home_count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) check("empty_busy", 128'(busy), 128'(1));
            if (done) begin
                n = c;
                break;
            end
            tick();
        end
        check("empty_done_delay", 128'(n), 128'(2));
        tick();
        tick();

        set_counts(3);
        start_pass(2);
        finish_pass(20, 80, 1);

        set_counts(10);
        start_pass(3);
        wait_first_valid(ok);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_valid", 128'(input_valid), 128'(0));
        check("mid_rst_ref_id", 128'(ref_id), 128'(0));
        check("mid_rst_nb_addr", 128'(nb_rd_addr), 128'(0));
        check("mid_rst_nb_x", 128'(nb_x), 128'(0));
        check("mid_rst_ref_pos", {ref_z, ref_y, ref_x}, 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        set_counts(4);
        start_pass(2);
        finish_pass(10, 90, 0);

        set_counts(4);
        start_pass(4);
        finish_pass(0, 100, 0);
`ifdef PAIR_DISPATCH_HALF_HOME_EN
        check("home_lane_4x4", 128'(lane_cnt[0]), 128'(6));
`else
        check("home_lane_4x4", 128'(lane_cnt[0]), 128'(12));
`endif

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NF; i++)
                cfg_cnt[i] = ($urandom_range(4) == 0) ? 0 : $urandom_range(1, 6);
            start_pass($urandom_range(1, 6));
            finish_pass(25, 75, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
